wt_mem_arbiter: RTL and testbench
=================================

WT_MEM_ARBITER -- requirements
Module: wt_mem_arbiter

Interface
REQ-001 Parameter MemTidWidth, default 2: width of each requester transaction ID.
REQ-002 Parameter MaxOutstandingStores, default 7: cap on unacknowledged stores in flight.
REQ-003 Parameters AddrWidth 64, DataWidth 64: request address and data widths.
REQ-004 clk_i  in  1  single clock, all state on rising edge.
REQ-005 rst_ni  in  1  synchronous active-low reset.
REQ-006 icache_req_valid_i / icache_req_ready_o  in/out  1  instruction-miss read request handshake.
REQ-007 icache_req_addr_i  in  AddrWidth; icache_req_tid_i  in  MemTidWidth.
REQ-008 dcache_req_valid_i / dcache_req_ready_o  in/out  1  data request handshake.
REQ-009 dcache_req_addr_i  in  AddrWidth; dcache_req_data_i  in  DataWidth; dcache_req_be_i  in  DataWidth/8; dcache_req_store_i  in  1; dcache_req_tid_i  in  MemTidWidth.
REQ-010 mem_req_valid_o / mem_req_ready_i  out/in  1  shared memory request handshake.
REQ-011 mem_req_addr_o, mem_req_data_o, mem_req_be_o, mem_req_store_o  out  as inputs; mem_req_id_o  out  MemTidWidth+1  {src, tid}, src 0=icache, 1=dcache.
REQ-012 mem_rsp_valid_i  in  1; mem_rsp_id_i  in  MemTidWidth+1; mem_rsp_store_ack_i  in  1  response is a store acknowledge.
REQ-013 icache_rsp_valid_o, dcache_rsp_valid_o  out  1; icache_rsp_tid_o, dcache_rsp_tid_o  out  MemTidWidth; dcache_rsp_store_ack_o  out  1.
REQ-014 drain_i  in  1  stop granting new requests; drained_o  out  1  nothing outstanding and output stage empty.

Function
REQ-015 Output stage SHALL be one register; a grant loads it when empty or when mem_req_valid_o && mem_req_ready_i that cycle (one-cycle request latency, full throughput).
REQ-016 While mem_req_valid_o=1 and mem_req_ready_i=0, all mem_req_* outputs SHALL hold stable.
REQ-017 Arbitration SHALL be round-robin between icache and dcache; winner loses priority next grant; ties with no history after reset favour dcache.
REQ-018 A requester is eligible only if its {src,tid} is not marked busy in the 2^(MemTidWidth+1)-bit outstanding bitmap.
REQ-019 A dcache store is eligible only if store count < MaxOutstandingStores; loads are not limited by this count.
REQ-020 *_req_ready_o SHALL be asserted only in the cycle that requester is granted (combinational from valid, eligibility, arbitration, stage availability).
REQ-021 Grant SHALL set the busy bit of its id; response with that id SHALL clear it; set and clear of the same bit in one cycle -> bit ends set only if ids differ from the cleared one.
REQ-022 Store count +1 on granted store, -1 on mem_rsp_store_ack_i; simultaneous -> unchanged; ack at zero count SHALL be ignored (no underflow).
REQ-023 Responses SHALL be routed combinationally by mem_rsp_id_i MSB to icache or dcache with tid=LSBs, zero latency; response with an id not busy SHALL still be routed.
REQ-024 drain_i=1 SHALL suppress new grants; a request already in the output stage completes.
REQ-025 drained_o = output stage empty && bitmap all zero && store count zero.

Reset
REQ-026 On rst_ni=0 at a clock edge: output stage empty (mem_req_valid_o=0, payload 0), bitmap 0, store count 0, round-robin pointer to dcache-priority; drained_o=1 next cycle; reset mid-transaction discards all tracking.

Structure
REQ-027 Id width, src encoding and request/response struct typedefs SHALL live in the shared wt_cache_pkg.
REQ-028 Round-robin selection SHALL be one sub-module, rr_arb_2, reused for the two requesters.

Verification
REQ-029 Both valid after reset, ready_i=1 -> dcache granted cycle 1, icache cycle 2, alternating thereafter.
REQ-030 Seven dcache stores, no acks -> eighth store held (ready_o=0) while an icache read still granted; one ack -> eighth granted next cycle.
REQ-031 mem_req_ready_i=0 for 5 cycles with valid_o=1 -> outputs bit-stable, no further ready_o to requesters.
REQ-032 icache tid 2 outstanding, icache requests tid 2 again -> stalled until response id 0b010, then granted.
REQ-033 Store grant and store ack same cycle at count 3 -> count stays 3.
REQ-034 drain_i=1 with 2 loads outstanding -> no grants, drained_o rises the cycle after last response; rst_ni=0 mid-traffic -> valid_o=0, drained_o=1.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// rtl/wt_cache_pkg.sv - shared id layout, source encoding and memory request/response types
package wt_cache_pkg;

  localparam int unsigned DefMemTidWidth = 2;
  localparam int unsigned DefAddrWidth   = 64;
  localparam int unsigned DefDataWidth   = 64;
  localparam int unsigned DefMemIdWidth  = DefMemTidWidth + 1;

  // Requester slots shared by the round-robin arbiter and the id MSB
  localparam int unsigned RrIdxIcache = 0;
  localparam int unsigned RrIdxDcache = 1;

  // MSB of a memory id names the requester that owns it
  typedef enum logic {
    SRC_ICACHE = 1'b0,
    SRC_DCACHE = 1'b1
  } mem_src_e;

  typedef struct packed {
    logic [DefAddrWidth-1:0]   addr;
    logic [DefDataWidth-1:0]   data;
    logic [DefDataWidth/8-1:0] be;
    logic                      store;
    logic [DefMemIdWidth-1:0]  id;
  } mem_req_t;

  typedef struct packed {
    logic                     valid;
    logic [DefMemIdWidth-1:0] id;
    logic                     store_ack;
  } mem_rsp_t;

  // A memory id is the requester tid with the source bit prepended
  function automatic int unsigned mem_id_width(input int unsigned tid_width);
    return tid_width + 1;
  endfunction

endpackage

// File: rtl/rr_arb_2.sv
// rtl/rr_arb_2.sv - two-way round-robin arbiter, dcache favoured out of reset
module rr_arb_2
  import wt_cache_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // 1: dcache slot holds priority for the next contested grant
  logic r_prio_dc;

  // Pick the priority holder when both request, otherwise whoever requests
  always_comb begin
    o_gnt = 2'b00;
    if (i_req[RrIdxDcache] && (r_prio_dc || !i_req[RrIdxIcache])) begin
      o_gnt[RrIdxDcache] = 1'b1;
    end else if (i_req[RrIdxIcache]) begin
      o_gnt[RrIdxIcache] = 1'b1;
    end
  end

  // The winner hands priority to the other side
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prio_dc <= 1'b1;
    end else if (o_gnt[RrIdxDcache]) begin
      r_prio_dc <= 1'b0;
    end else if (o_gnt[RrIdxIcache]) begin
      r_prio_dc <= 1'b1;
    end
  end

endmodule

// File: rtl/wt_mem_arbiter.sv
// rtl/wt_mem_arbiter.sv - icache/dcache request arbiter onto one memory port
module wt_mem_arbiter
  import wt_cache_pkg::*;
#(
  parameter int unsigned MemTidWidth          = 2,
  parameter int unsigned MaxOutstandingStores = 7,
  parameter int unsigned AddrWidth            = 64,
  parameter int unsigned DataWidth            = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     icache_req_valid_i,
  output logic                     icache_req_ready_o,
  input  logic [AddrWidth-1:0]     icache_req_addr_i,
  input  logic [MemTidWidth-1:0]   icache_req_tid_i,
  input  logic                     dcache_req_valid_i,
  output logic                     dcache_req_ready_o,
  input  logic [AddrWidth-1:0]     dcache_req_addr_i,
  input  logic [DataWidth-1:0]     dcache_req_data_i,
  input  logic [DataWidth/8-1:0]   dcache_req_be_i,
  input  logic                     dcache_req_store_i,
  input  logic [MemTidWidth-1:0]   dcache_req_tid_i,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic [AddrWidth-1:0]     mem_req_addr_o,
  output logic [DataWidth-1:0]     mem_req_data_o,
  output logic [DataWidth/8-1:0]   mem_req_be_o,
  output logic                     mem_req_store_o,
  output logic [MemTidWidth:0]     mem_req_id_o,
  input  logic                     mem_rsp_valid_i,
  input  logic [MemTidWidth:0]     mem_rsp_id_i,
  input  logic                     mem_rsp_store_ack_i,
  output logic                     icache_rsp_valid_o,
  output logic [MemTidWidth-1:0]   icache_rsp_tid_o,
  output logic                     dcache_rsp_valid_o,
  output logic [MemTidWidth-1:0]   dcache_rsp_tid_o,
  output logic                     dcache_rsp_store_ack_o,
  input  logic                     drain_i,
  output logic                     drained_o
);

  localparam int unsigned IdWidth  = mem_id_width(MemTidWidth);
  localparam int unsigned NumIds   = 1 << IdWidth;
  localparam int unsigned CntWidth = $clog2(MaxOutstandingStores + 1);
  localparam logic [CntWidth-1:0] MaxStores = CntWidth'(MaxOutstandingStores);

  logic                   r_valid;
  logic [AddrWidth-1:0]   r_addr;
  logic [DataWidth-1:0]   r_data;
  logic [DataWidth/8-1:0] r_be;
  logic                   r_store;
  logic [IdWidth-1:0]     r_id;
  logic [NumIds-1:0]      r_busy;
  logic [CntWidth-1:0]    r_store_cnt;

  logic [IdWidth-1:0] w_ic_id;
  logic [IdWidth-1:0] w_dc_id;
  logic [IdWidth-1:0] w_gnt_id;
  logic               w_stage_free;
  logic               w_ic_elig;
  logic               w_dc_elig;
  logic [1:0]         w_req;
  logic [1:0]         w_gnt;
  logic               w_grant;
  logic               w_gnt_dc;
  logic               w_cnt_inc;
  logic               w_cnt_dec;
  logic [NumIds-1:0]  w_busy_set;
  logic [NumIds-1:0]  w_busy_clr;

  assign w_ic_id = {SRC_ICACHE, icache_req_tid_i};
  assign w_dc_id = {SRC_DCACHE, dcache_req_tid_i};

  // The stage can take a new request if empty or if it is leaving this cycle
  assign w_stage_free = !r_valid || mem_req_ready_i;

  assign w_ic_elig = icache_req_valid_i && !r_busy[w_ic_id];
  assign w_dc_elig = dcache_req_valid_i && !r_busy[w_dc_id] &&
                     (!dcache_req_store_i || (r_store_cnt < MaxStores));

  assign w_req[RrIdxIcache] = w_ic_elig && w_stage_free && !drain_i;
  assign w_req[RrIdxDcache] = w_dc_elig && w_stage_free && !drain_i;

  rr_arb_2 u_rr_arb (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_req   (w_req),
    .o_gnt   (w_gnt)
  );

  assign w_gnt_dc = w_gnt[RrIdxDcache];
  assign w_grant  = |w_gnt;
  assign w_gnt_id = w_gnt_dc ? w_dc_id : w_ic_id;

  assign icache_req_ready_o = w_gnt[RrIdxIcache];
  assign dcache_req_ready_o = w_gnt[RrIdxDcache];

  // Output register: load on grant, empty once the memory side accepts it
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_be    <= '0;
      r_store <= 1'b0;
      r_id    <= '0;
    end else if (w_grant) begin
      // icache fetches carry no write payload
      r_valid <= 1'b1;
      r_addr  <= w_gnt_dc ? dcache_req_addr_i : icache_req_addr_i;
      r_data  <= w_gnt_dc ? dcache_req_data_i : '0;
      r_be    <= w_gnt_dc ? dcache_req_be_i : '0;
      r_store <= w_gnt_dc && dcache_req_store_i;
      r_id    <= w_gnt_id;
    end else if (mem_req_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  // One-hot set/clear masks; a clear of the same id as a set wins
  always_comb begin
    w_busy_set = '0;
    w_busy_clr = '0;
    if (w_grant) begin
      w_busy_set[w_gnt_id] = 1'b1;
    end
    if (mem_rsp_valid_i) begin
      w_busy_clr[mem_rsp_id_i] = 1'b1;
    end
  end

  // Outstanding id bitmap
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy | w_busy_set) & ~w_busy_clr;
    end
  end

  assign w_cnt_inc = w_gnt_dc && dcache_req_store_i;
  assign w_cnt_dec = mem_rsp_valid_i && mem_rsp_store_ack_i && (r_store_cnt != '0);

  // Unacknowledged store counter; a stray ack at zero is dropped
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_store_cnt <= '0;
    end else if (w_cnt_inc && !w_cnt_dec) begin
      r_store_cnt <= r_store_cnt + 1'b1;
    end else if (w_cnt_dec && !w_cnt_inc) begin
      r_store_cnt <= r_store_cnt - 1'b1;
    end
  end

  assign mem_req_valid_o = r_valid;
  assign mem_req_addr_o  = r_addr;
  assign mem_req_data_o  = r_data;
  assign mem_req_be_o    = r_be;
  assign mem_req_store_o = r_store;
  assign mem_req_id_o    = r_id;

  // Responses steer on the source bit alone, even for ids not marked busy
  assign icache_rsp_valid_o     = mem_rsp_valid_i && (mem_rsp_id_i[IdWidth-1] == SRC_ICACHE);
  assign dcache_rsp_valid_o     = mem_rsp_valid_i && (mem_rsp_id_i[IdWidth-1] == SRC_DCACHE);
  assign icache_rsp_tid_o       = mem_rsp_id_i[MemTidWidth-1:0];
  assign dcache_rsp_tid_o       = mem_rsp_id_i[MemTidWidth-1:0];
  assign dcache_rsp_store_ack_o = dcache_rsp_valid_o && mem_rsp_store_ack_i;

  assign drained_o = !r_valid && (r_busy == '0) && (r_store_cnt == '0);

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// tb/tb_wt_mem_arbiter.sv - scoreboard bench for wt_mem_arbiter
module tb_wt_mem_arbiter;

  localparam int TW = 3;
  localparam int IW = TW + 1;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int BW = DW / 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] be;
    logic          store;
    logic [IW-1:0] id;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          ic_valid;
  logic          ic_ready;
  logic [AW-1:0] ic_addr;
  logic [TW-1:0] ic_tid;
  logic          dc_valid;
  logic          dc_ready;
  logic [AW-1:0] dc_addr;
  logic [DW-1:0] dc_data;
  logic [BW-1:0] dc_be;
  logic          dc_store;
  logic [TW-1:0] dc_tid;
  logic          mem_req_valid_o;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr_o;
  logic [DW-1:0] mem_req_data_o;
  logic [BW-1:0] mem_req_be_o;
  logic          mem_req_store_o;
  logic [IW-1:0] mem_req_id_o;
  logic          rsp_valid;
  logic [IW-1:0] rsp_id;
  logic          rsp_ack;
  logic          icache_rsp_valid_o;
  logic [TW-1:0] icache_rsp_tid_o;
  logic          dcache_rsp_valid_o;
  logic [TW-1:0] dcache_rsp_tid_o;
  logic          dcache_rsp_store_ack_o;
  logic          drain;
  logic          drained_o;

  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  wt_mem_arbiter #(
    .MemTidWidth          (TW),
    .MaxOutstandingStores (7),
    .AddrWidth            (AW),
    .DataWidth            (DW)
  ) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .icache_req_valid_i     (ic_valid),
    .icache_req_ready_o     (ic_ready),
    .icache_req_addr_i      (ic_addr),
    .icache_req_tid_i       (ic_tid),
    .dcache_req_valid_i     (dc_valid),
    .dcache_req_ready_o     (dc_ready),
    .dcache_req_addr_i      (dc_addr),
    .dcache_req_data_i      (dc_data),
    .dcache_req_be_i        (dc_be),
    .dcache_req_store_i     (dc_store),
    .dcache_req_tid_i       (dc_tid),
    .mem_req_valid_o        (mem_req_valid_o),
    .mem_req_ready_i        (mem_req_ready),
    .mem_req_addr_o         (mem_req_addr_o),
    .mem_req_data_o         (mem_req_data_o),
    .mem_req_be_o           (mem_req_be_o),
    .mem_req_store_o        (mem_req_store_o),
    .mem_req_id_o           (mem_req_id_o),
    .mem_rsp_valid_i        (rsp_valid),
    .mem_rsp_id_i           (rsp_id),
    .mem_rsp_store_ack_i    (rsp_ack),
    .icache_rsp_valid_o     (icache_rsp_valid_o),
    .icache_rsp_tid_o       (icache_rsp_tid_o),
    .dcache_rsp_valid_o     (dcache_rsp_valid_o),
    .dcache_rsp_tid_o       (dcache_rsp_tid_o),
    .dcache_rsp_store_ack_o (dcache_rsp_store_ack_o),
    .drain_i                (drain),
    .drained_o              (drained_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  function automatic exp_t mk_ic(input logic [AW-1:0] a, input logic [TW-1:0] t);
    exp_t e;
    e.addr  = a;
    e.data  = '0;
    e.be    = '0;
    e.store = 1'b0;
    e.id    = {1'b0, t};
    return e;
  endfunction

  function automatic exp_t mk_dc(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [BW-1:0] b, input logic st, input logic [TW-1:0] t);
    exp_t e;
    e.addr  = a;
    e.data  = d;
    e.be    = b;
    e.store = st;
    e.id    = {1'b1, t};
    return e;
  endfunction

  task automatic set_ic(input logic v, input logic [TW-1:0] t);
    ic_valid = v;
    ic_tid   = t;
    ic_addr  = rnd64();
  endtask

  task automatic set_dc(input logic v, input logic st, input logic [TW-1:0] t);
    dc_valid = v;
    dc_store = st;
    dc_tid   = t;
    dc_addr  = rnd64();
    dc_data  = rnd64();
    dc_be    = BW'($urandom());
  endtask

  task automatic rsp(input logic [IW-1:0] id, input logic ack);
    rsp_valid = 1'b1;
    rsp_id    = id;
    rsp_ack   = ack;
    smp();
    tick();
    rsp_valid = 1'b0;
    rsp_ack   = 1'b0;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    ic_valid      = 1'b0;
    dc_valid      = 1'b0;
    dc_store      = 1'b0;
    mem_req_ready = 1'b0;
    rsp_valid     = 1'b0;
    rsp_ack       = 1'b0;
    rsp_id        = '0;
    drain         = 1'b0;
    tick();
    tick();
    sb.delete();
    rst_n = 1'b1;
  endtask

  // Every accepted memory request must match the oldest expected one
  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (rst_n && mem_req_valid_o && mem_req_ready) begin
      got = {mem_req_addr_o, mem_req_data_o, mem_req_be_o, mem_req_store_o, mem_req_id_o};
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got id=%h addr=%h, required no request", mem_req_id_o, mem_req_addr_o);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_errors++;
          $display("FAIL sb_req: got id=%h addr=%h data=%h be=%h st=%b, required id=%h addr=%h data=%h be=%h st=%b",
                   got.id, got.addr, got.data, got.be, got.store, e.id, e.addr, e.data, e.be, e.store);
        end
      end
    end
  end

  task automatic test_reset();
    do_reset();
    smp();
    n_checks++;
    if (mem_req_valid_o !== 1'b0 || mem_req_addr_o !== '0 || mem_req_id_o !== '0 || mem_req_data_o !== '0) begin
      n_errors++;
      $display("FAIL reset_stage: got valid=%b addr=%h id=%h, required 0", mem_req_valid_o, mem_req_addr_o, mem_req_id_o);
    end
    n_checks++;
    if (drained_o !== 1'b1 || ic_ready !== 1'b0 || dc_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got drained=%b ic_rdy=%b dc_rdy=%b, required 1 0 0", drained_o, ic_ready, dc_ready);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [TW-1:0] ti;
    logic [TW-1:0] td;
    logic [IW-1:0] rid;
    logic          exp_dc;
    do_reset();
    mem_req_ready = 1'b1;
    ti = '0;
    td = '0;
    for (int k = 0; k < 8; k++) begin
      set_ic(1'b1, ti);
      set_dc(1'b1, 1'b0, td);
      smp();
      exp_dc = (k % 2 == 0);
      n_checks++;
      if ({dc_ready, ic_ready} !== (exp_dc ? 2'b10 : 2'b01)) begin
        n_errors++;
        $display("FAIL rr_grant[%0d]: got dc/ic=%b%b, required dc=%b", k, dc_ready, ic_ready, exp_dc);
      end
      if (exp_dc) begin
        sb.push_back(mk_dc(dc_addr, dc_data, dc_be, 1'b0, td));
        td = td + 1'b1;
      end else begin
        sb.push_back(mk_ic(ic_addr, ti));
        ti = ti + 1'b1;
      end
      tick();
    end
    ic_valid = 1'b0;
    dc_valid = 1'b0;
    smp();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL rr_sb_empty: got %0d pending, required 0", sb.size());
    end
    for (int j = 0; j < 8; j++) begin
      rid       = (j < 4) ? IW'(j) : IW'(8 + j - 4);
      rsp_valid = 1'b1;
      rsp_id    = rid;
      smp();
      n_checks++;
      if (j < 4) begin
        if (icache_rsp_valid_o !== 1'b1 || dcache_rsp_valid_o !== 1'b0 || icache_rsp_tid_o !== TW'(j)) begin
          n_errors++;
          $display("FAIL rsp_route_ic[%0d]: got ic=%b dc=%b tid=%0d, required ic=1 dc=0 tid=%0d",
                   j, icache_rsp_valid_o, dcache_rsp_valid_o, icache_rsp_tid_o, j);
        end
      end else begin
        if (dcache_rsp_valid_o !== 1'b1 || icache_rsp_valid_o !== 1'b0 || dcache_rsp_tid_o !== TW'(j - 4)) begin
          n_errors++;
          $display("FAIL rsp_route_dc[%0d]: got ic=%b dc=%b tid=%0d, required ic=0 dc=1 tid=%0d",
                   j, icache_rsp_valid_o, dcache_rsp_valid_o, dcache_rsp_tid_o, j - 4);
        end
      end
      tick();
    end
    rsp_valid = 1'b0;
    smp();
    n_checks++;
    if (drained_o !== 1'b1) begin
      n_errors++;
      $display("FAIL rr_drained: got %b, required 1", drained_o);
    end
    tick();
  endtask

  task automatic test_store_limit();
    do_reset();
    mem_req_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      set_dc(1'b1, 1'b1, TW'(k));
      smp();
      n_checks++;
      if (dc_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL store_fill[%0d]: got ready=%b, required 1", k, dc_ready);
      end
      sb.push_back(mk_dc(dc_addr, dc_data, dc_be, 1'b1, TW'(k)));
      tick();
    end
    set_dc(1'b1, 1'b1, TW'(7));
    set_ic(1'b1, '0);
    smp();
    n_checks++;
    if (dc_ready !== 1'b0 || ic_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL store_cap: got dc=%b ic=%b, required dc=0 ic=1", dc_ready, ic_ready);
    end
    sb.push_back(mk_ic(ic_addr, '0));
    tick();
    ic_valid  = 1'b0;
    rsp_valid = 1'b1;
    rsp_id    = {1'b1, 3'd0};
    rsp_ack   = 1'b1;
    smp();
    n_checks++;
    if (dc_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL store_cap_ack_cycle: got ready=%b, required 0", dc_ready);
    end
    tick();
    rsp_valid = 1'b0;
    rsp_ack   = 1'b0;
    smp();
    n_checks++;
    if (dc_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL store_after_ack: got ready=%b, required 1", dc_ready);
    end
    sb.push_back(mk_dc(dc_addr, dc_data, dc_be, 1'b1, TW'(7)));
    tick();
    dc_valid = 1'b0;
    for (int k = 1; k < 8; k++) begin
      rsp({1'b1, TW'(k)}, 1'b1);
    end
    rsp({1'b0, TW'(0)}, 1'b0);
    smp();
    n_checks++;
    if (drained_o !== 1'b1 || sb.size() != 0) begin
      n_errors++;
      $display("FAIL store_cleanup: got drained=%b pending=%0d, required 1 0", drained_o, sb.size());
    end
    tick();
  endtask

  task automatic test_backpressure();
    exp_t held;
    do_reset();
    set_dc(1'b1, 1'b0, TW'(1));
    smp();
    n_checks++;
    if (dc_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_first: got ready=%b, required 1", dc_ready);
    end
    held = mk_dc(dc_addr, dc_data, dc_be, 1'b0, TW'(1));
    sb.push_back(held);
    tick();
    set_dc(1'b1, 1'b0, TW'(2));
    set_ic(1'b1, TW'(3));
    for (int k = 0; k < 5; k++) begin
      smp();
      n_checks++;
      if (mem_req_valid_o !== 1'b1 ||
          {mem_req_addr_o, mem_req_data_o, mem_req_be_o, mem_req_store_o, mem_req_id_o} !== held ||
          ic_ready !== 1'b0 || dc_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%h addr=%h rdy=%b%b, required v=1 id=%h addr=%h rdy=00",
                 k, mem_req_valid_o, mem_req_id_o, mem_req_addr_o, dc_ready, ic_ready, held.id, held.addr);
      end
      tick();
    end
    mem_req_ready = 1'b1;
    smp();
    n_checks++;
    if (ic_ready !== 1'b1 || dc_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_release: got dc/ic=%b%b, required 01", dc_ready, ic_ready);
    end
    sb.push_back(mk_ic(ic_addr, TW'(3)));
    tick();
    ic_valid = 1'b0;
    smp();
    n_checks++;
    if (dc_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_next_dc: got ready=%b, required 1", dc_ready);
    end
    sb.push_back(mk_dc(dc_addr, dc_data, dc_be, 1'b0, TW'(2)));
    tick();
    dc_valid = 1'b0;
    smp();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL bp_sb_empty: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_busy_stall();
    do_reset();
    mem_req_ready = 1'b1;
    set_ic(1'b1, TW'(2));
    smp();
    sb.push_back(mk_ic(ic_addr, TW'(2)));
    tick();
    set_ic(1'b1, TW'(2));
    for (int k = 0; k < 3; k++) begin
      smp();
      n_checks++;
      if (ic_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL busy_stall[%0d]: got ready=%b, required 0", k, ic_ready);
      end
      tick();
    end
    rsp_valid = 1'b1;
    rsp_id    = {1'b0, TW'(2)};
    smp();
    n_checks++;
    if (ic_ready !== 1'b0 || icache_rsp_valid_o !== 1'b1 || icache_rsp_tid_o !== TW'(2) || dcache_rsp_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_rsp_cycle: got rdy=%b icv=%b tid=%0d dcv=%b, required 0 1 2 0",
               ic_ready, icache_rsp_valid_o, icache_rsp_tid_o, dcache_rsp_valid_o);
    end
    tick();
    rsp_valid = 1'b0;
    smp();
    n_checks++;
    if (ic_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL busy_regrant: got ready=%b, required 1", ic_ready);
    end
    sb.push_back(mk_ic(ic_addr, TW'(2)));
    tick();
    ic_valid = 1'b0;
    smp();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL busy_sb_empty: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_store_simul();
    do_reset();
    mem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_dc(1'b1, 1'b1, TW'(k));
      smp();
      sb.push_back(mk_dc(dc_addr, dc_data, dc_be, 1'b1, TW'(k)));
      tick();
    end
    set_dc(1'b1, 1'b1, TW'(3));
    rsp_valid = 1'b1;
    rsp_id    = {1'b1, TW'(0)};
    rsp_ack   = 1'b1;
    smp();
    n_checks++;
    if (dc_ready !== 1'b1 || dcache_rsp_store_ack_o !== 1'b1) begin
      n_errors++;
      $display("FAIL simul_grant_ack: got rdy=%b ack=%b, required 1 1", dc_ready, dcache_rsp_store_ack_o);
    end
    sb.push_back(mk_dc(dc_addr, dc_data, dc_be, 1'b1, TW'(3)));
    tick();
    dc_valid  = 1'b0;
    rsp_valid = 1'b0;
    rsp_ack   = 1'b0;
    rsp({1'b1, TW'(1)}, 1'b1);
    rsp({1'b1, TW'(2)}, 1'b1);
    rsp({1'b1, TW'(3)}, 1'b0);
    smp();
    n_checks++;
    if (drained_o !== 1'b0) begin
      n_errors++;
      $display("FAIL simul_count3: got drained=%b, required 0 (one store still counted)", drained_o);
    end
    tick();
    rsp_valid = 1'b1;
    rsp_id    = {1'b1, TW'(0)};
    rsp_ack   = 1'b1;
    smp();
    n_checks++;
    if (dcache_rsp_valid_o !== 1'b1 || dcache_rsp_tid_o !== TW'(0) || dcache_rsp_store_ack_o !== 1'b1) begin
      n_errors++;
      $display("FAIL stray_route: got v=%b tid=%0d ack=%b, required 1 0 1",
               dcache_rsp_valid_o, dcache_rsp_tid_o, dcache_rsp_store_ack_o);
    end
    tick();
    rsp_valid = 1'b0;
    rsp_ack   = 1'b0;
    smp();
    n_checks++;
    if (drained_o !== 1'b1) begin
      n_errors++;
      $display("FAIL simul_count0: got drained=%b, required 1", drained_o);
    end
    tick();
    rsp({1'b1, TW'(0)}, 1'b1);
    set_dc(1'b1, 1'b1, TW'(5));
    smp();
    n_checks++;
    if (dc_ready !== 1'b1 || drained_o !== 1'b1) begin
      n_errors++;
      $display("FAIL ack_at_zero: got rdy=%b drained=%b, required 1 1", dc_ready, drained_o);
    end
    sb.push_back(mk_dc(dc_addr, dc_data, dc_be, 1'b1, TW'(5)));
    tick();
    dc_valid = 1'b0;
    smp();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL simul_sb_empty: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_drain();
    do_reset();
    mem_req_ready = 1'b1;
    set_ic(1'b1, TW'(0));
    set_dc(1'b1, 1'b0, TW'(0));
    smp();
    n_checks++;
    if ({dc_ready, ic_ready} !== 2'b10) begin
      n_errors++;
      $display("FAIL drain_setup_dc: got dc/ic=%b%b, required 10", dc_ready, ic_ready);
    end
    sb.push_back(mk_dc(dc_addr, dc_data, dc_be, 1'b0, TW'(0)));
    tick();
    dc_valid = 1'b0;
    smp();
    sb.push_back(mk_ic(ic_addr, TW'(0)));
    tick();
    drain = 1'b1;
    set_ic(1'b1, TW'(1));
    set_dc(1'b1, 1'b0, TW'(1));
    for (int k = 0; k < 3; k++) begin
      smp();
      n_checks++;
      if (ic_ready !== 1'b0 || dc_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL drain_no_grant[%0d]: got dc/ic=%b%b, required 00", k, dc_ready, ic_ready);
      end
      tick();
    end
    n_checks++;
    if (sb.size() != 0 || drained_o !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_pending: got pending=%0d drained=%b, required 0 0", sb.size(), drained_o);
    end
    rsp({1'b1, TW'(0)}, 1'b0);
    rsp_valid = 1'b1;
    rsp_id    = {1'b0, TW'(0)};
    smp();
    n_checks++;
    if (drained_o !== 1'b0) begin
      n_errors++;
      $display("FAIL drain_last_rsp_cycle: got drained=%b, required 0", drained_o);
    end
    tick();
    rsp_valid = 1'b0;
    smp();
    n_checks++;
    if (drained_o !== 1'b1) begin
      n_errors++;
      $display("FAIL drain_done: got drained=%b, required 1", drained_o);
    end
    tick();
    drain    = 1'b0;
    ic_valid = 1'b0;
    dc_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_dc(1'b1, 1'b0, TW'(4));
    smp();
    sb.push_back(mk_dc(dc_addr, dc_data, dc_be, 1'b0, TW'(4)));
    tick();
    set_ic(1'b1, TW'(5));
    smp();
    tick();
    rst_n    = 1'b0;
    ic_valid = 1'b0;
    dc_valid = 1'b0;
    tick();
    smp();
    n_checks++;
    if (mem_req_valid_o !== 1'b0 || drained_o !== 1'b1 || mem_req_addr_o !== '0) begin
      n_errors++;
      $display("FAIL reset_mid: got valid=%b drained=%b addr=%h, required 0 1 0", mem_req_valid_o, drained_o, mem_req_addr_o);
    end
    sb.delete();
    rst_n = 1'b1;
    tick();
    mem_req_ready = 1'b1;
    set_dc(1'b1, 1'b0, TW'(4));
    smp();
    n_checks++;
    if (dc_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_busy_cleared: got ready=%b, required 1", dc_ready);
    end
    sb.push_back(mk_dc(dc_addr, dc_data, dc_be, 1'b0, TW'(4)));
    tick();
    dc_valid = 1'b0;
    smp();
    tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL reset_mid_sb_empty: got %0d pending, required 0", sb.size());
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    ic_valid      = 1'b0;
    ic_addr       = '0;
    ic_tid        = '0;
    dc_valid      = 1'b0;
    dc_addr       = '0;
    dc_data       = '0;
    dc_be         = '0;
    dc_store      = 1'b0;
    dc_tid        = '0;
    mem_req_ready = 1'b0;
    rsp_valid     = 1'b0;
    rsp_id        = '0;
    rsp_ack       = 1'b0;
    drain         = 1'b0;
    tick();
    test_reset();
    test_round_robin();
    test_store_limit();
    test_backpressure();
    test_busy_stall();
    test_store_simul();
    test_drain();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
